rectangle_fill: RTL

Rectangle fill engine feeding the memory arbiter's `rectanglefill` request port. It accepts one fill command at a time: origin, size and 8-bit colour. It walks the covered framebuffer words row by row and issues one masked 32-bit write per word through the arbiter's rts/rtr handshake. The framebuffer is 320x240 at 8 bpp, packed four pixels per word, with 80 words per line.

---
 rtl/gfx_pkg.sv | 22 ++
 rtl/rect_edge_mask.sv | 30 +++
 rtl/rectangle_fill.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared framebuffer geometry, write-enable constants and fill FSM state type
package gfx_pkg;

    localparam int H_RES          = 320;
    localparam int V_RES          = 240;
    localparam int WORDS_PER_LINE = H_RES / 4;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_WR_NONE = 4'b0000;
    localparam logic [OP_W-1:0] OP_WR_ALL  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ROW,
        ST_DONE
    } fill_state_t;

endpackage

// File: rtl/rect_edge_mask.sv
// rtl/rect_edge_mask.sv - byte write-enable for one word of a rectangle row
//
// Ports:
//   x0_lo    in  2  x0[1:0], first pixel lane of the row
//   x1_lo    in  2  x1[1:0], last pixel lane of the row
//   is_first in  1  current word is the row's first word
//   is_last  in  1  current word is the row's last word
//   mask     out 4  byte enables, bit k covers pixel x%4==k
module rect_edge_mask
    import gfx_pkg::*;
(
    input  logic [1:0]      x0_lo,
    input  logic [1:0]      x1_lo,
    input  logic            is_first,
    input  logic            is_last,
    output logic [OP_W-1:0] mask
);

    // A single-word row is both first and last, so both trims apply.
    always_comb begin
        mask = OP_WR_ALL;
        if (is_first) begin
            mask = mask & (OP_WR_ALL << x0_lo);
        end
        if (is_last) begin
            mask = mask & (OP_WR_ALL >> (2'd3 - x1_lo));
        end
    end

endmodule

// File: rtl/rectangle_fill.sv
// rtl/rectangle_fill.sv - rectangle fill engine issuing masked word writes to the memory arbiter
//
// Optional feature macro: RECT_FILL_CLIP_EN (clip rectangle to the visible framebuffer).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_x0/y0/w/h/color      fill command fields
//   cmd_rts_in/cmd_rtr_out   command handshake
//   rectanglefill_addr       word address (17 bits)
//   rectanglefill_wrdata     {4{color}}
//   rectanglefill_op         byte write enables
//   rectanglefill_rts_out    write request valid
//   rectanglefill_rtr_in     arbiter ready
//   done                     one-cycle completion pulse
//   busy                     command in progress
module rectangle_fill
    import gfx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [8:0]        cmd_x0,
    input  logic [7:0]        cmd_y0,
    input  logic [8:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [7:0]        cmd_color,
    input  logic              cmd_rts_in,
    output logic              cmd_rtr_out,
    output logic [ADDR_W-1:0] rectanglefill_addr,
    output logic [DATA_W-1:0] rectanglefill_wrdata,
    output logic [OP_W-1:0]   rectanglefill_op,
    output logic              rectanglefill_rts_out,
    input  logic              rectanglefill_rtr_in,
    output logic              done,
    output logic              busy
);

    fill_state_t state, state_next;

    // ready_q keeps cmd_rtr_out low until the first clock after reset release.
    logic              ready_q;
    logic [8:0]        x0_q;
    logic [7:0]        y0_q;
    logic [8:0]        w_q;
    logic [7:0]        h_q;
    logic [7:0]        color_q;
    logic [1:0]        x1_lo;
    logic [7:0]        start_w;
    logic [7:0]        end_w;
    logic [7:0]        idx;
    logic [8:0]        line;
    logic [8:0]        y1_q;
    logic [ADDR_W-1:0] row_base;

    logic [9:0]        x1_full;
    logic [8:0]        y1_full;
    logic [9:0]        x1_clip;
    logic [8:0]        y1_clip;
    logic              empty;
    logic [ADDR_W-1:0] base_calc;

    logic              idle_ready;
    logic              cmd_accept;
    logic              xfc;
    logic              row_end;
    logic              last_row;
    logic [OP_W-1:0]   mask;

    assign idle_ready = (state == ST_IDLE) && ready_q;
    assign cmd_accept = cmd_rts_in && idle_ready;
    assign xfc        = rectanglefill_rts_out && rectanglefill_rtr_in;
    assign row_end    = (idx == end_w);
    assign last_row   = (line == y1_q);

    // Extents are one bit wider than the inputs so x0+w-1 never truncates.
    assign x1_full   = {1'b0, x0_q} + {1'b0, w_q} - 10'd1;
    assign y1_full   = {1'b0, y0_q} + {1'b0, h_q} - 9'd1;
    assign base_calc = ({9'd0, y0_q} << 6) + ({9'd0, y0_q} << 4);

    always_comb begin
        x1_clip = x1_full;
        y1_clip = y1_full;
        empty   = (w_q == 9'd0) || (h_q == 8'd0);
`ifdef RECT_FILL_CLIP_EN
        if (x1_full > 10'(H_RES - 1)) begin
            x1_clip = 10'(H_RES - 1);
        end
        if (y1_full > 9'(V_RES - 1)) begin
            y1_clip = 9'(V_RES - 1);
        end
        if (({1'b0, x0_q} >= 10'(H_RES)) || ({1'b0, y0_q} >= 9'(V_RES))) begin
            empty = 1'b1;
        end
`endif
    end

    rect_edge_mask u_mask (
        .x0_lo    (x0_q[1:0]),
        .x1_lo    (x1_lo),
        .is_first (idx == start_w),
        .is_last  (row_end),
        .mask     (mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next            = state;
        cmd_rtr_out           = 1'b0;
        rectanglefill_rts_out = 1'b0;
        done                  = 1'b0;
        busy                  = 1'b1;
        case (state)
            ST_IDLE: begin
                busy        = 1'b0;
                cmd_rtr_out = idle_ready;
                if (cmd_accept) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = empty ? ST_DONE : ST_ROW;
            end
            ST_ROW: begin
                rectanglefill_rts_out = 1'b1;
                if (xfc && row_end && last_row) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q  <= 1'b0;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            x1_lo    <= '0;
            start_w  <= '0;
            end_w    <= '0;
            idx      <= '0;
            line     <= '0;
            y1_q     <= '0;
            row_base <= '0;
        end else begin
            ready_q <= 1'b1;
            if (cmd_accept) begin
                x0_q    <= cmd_x0;
                y0_q    <= cmd_y0;
                w_q     <= cmd_w;
                h_q     <= cmd_h;
                color_q <= cmd_color;
            end
            if (state == ST_SETUP) begin
                x1_lo    <= x1_clip[1:0];
                start_w  <= {1'b0, x0_q[8:2]};
                end_w    <= x1_clip[9:2];
                idx      <= {1'b0, x0_q[8:2]};
                line     <= {1'b0, y0_q};
                y1_q     <= y1_clip;
                row_base <= base_calc;
            end
            // Row wrap happens on the last word's transfer so the next row
            // starts on the following cycle without a bubble.
            if (xfc) begin
                if (row_end) begin
                    idx      <= start_w;
                    row_base <= row_base + ADDR_W'(WORDS_PER_LINE);
                    line     <= line + 9'd1;
                end else begin
                    idx <= idx + 8'd1;
                end
            end
        end
    end

    assign rectanglefill_addr   = row_base + {9'd0, idx};
    assign rectanglefill_wrdata = {4{color_q}};
    assign rectanglefill_op     = rectanglefill_rts_out ? mask : OP_WR_NONE;

endmodule
